// File: rtl/vector_mem_seq_pkg.sv
// Shared state encoding and default geometry for the vector memory sequencer
// and the pipeline segment registers around it.
package vector_mem_seq_pkg;

  localparam int unsigned VMS_I = 32;
  localparam int unsigned VMS_N = 8;
  localparam int unsigned VMS_R = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } vmseq_state_t;

endpackage

// File: rtl/vmem_lane_buffer.sv
// R-lane read buffer: one lane written per completed load beat, cleared
// asynchronously so a reset never exposes a partially assembled vector.
module vmem_lane_buffer #(
  parameter int N  = 8,
  parameter int R  = 6,
  parameter int LW = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [LW-1:0]       lane_i,
  input  logic [N-1:0]        data_i,
  output logic [R-1:0][N-1:0] rdbuf_o
);

  logic [R-1:0][N-1:0] buf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else if (we_i) begin
      buf_q[lane_i] <= data_i;
    end
  end

  assign rdbuf_o = buf_q;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Serialises one R-lane vector load/store from the MEM stage onto an N-bit
// memory port, stalling the pipeline until every lane has been transferred.
module vector_mem_sequencer
  import vector_mem_seq_pkg::*;
#(
  parameter int I = VMS_I,
  parameter int N = VMS_N,
  parameter int R = VMS_R
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReqM,
  input  logic                MemWriteM,
  input  logic [I-1:0]        AddrM,
  input  logic [R-1:0][N-1:0] WriteDataM,
  input  logic [N-1:0]        mem_rdata,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [I-1:0]        mem_addr,
  output logic [N-1:0]        mem_wdata,
  output logic                StallM,
  output logic                DoneM,
  output logic [R-1:0][N-1:0] ReadDataM
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;

  vmseq_state_t        state_q, state_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [I-1:0]        base_q, base_d;
  logic [R-1:0][N-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                in_access;
  logic                buf_we;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          base_d  = AddrM;
          wdata_d = WriteDataM;
          we_d    = MemWriteM;
          lane_d  = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (lane_q == LW'(R - 1)) state_d = DONE;
          else                      lane_d  = lane_q + 1'b1;
        end
      end
      // MemReqM is still the finished instruction here, so it is not sampled.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign buf_we    = in_access & mem_ready & ~we_q;

  vmem_lane_buffer #(
    .N  (N),
    .R  (R),
    .LW (LW)
  ) u_lane_buffer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (buf_we),
    .lane_i  (lane_q),
    .data_i  (mem_rdata),
    .rdbuf_o (ReadDataM)
  );

  // Port outputs are decoded from registered state only; address wraps mod 2^I.
  assign mem_req   = in_access;
  assign mem_we    = in_access & we_q;
  assign mem_addr  = in_access ? (base_q + {{(I - LW){1'b0}}, lane_q}) : '0;
  assign mem_wdata = in_access ? wdata_q[lane_q] : '0;
  assign DoneM     = (state_q == DONE);

  // The request cycle stalls combinationally; reset masks it so the pipeline is released at once.
  assign StallM = in_access | ((state_q == IDLE) & MemReqM & reset);

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomised bench for vector_mem_sequencer with a transaction-level memory
// and expected-vector model.
module tb_vector_mem_sequencer;

  localparam int I = 32;
  localparam int N = 8;
  localparam int R = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                MemReqM;
  logic                MemWriteM;
  logic [I-1:0]        AddrM;
  logic [R-1:0][N-1:0] WriteDataM;
  logic [N-1:0]        mem_rdata;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic [I-1:0]        mem_addr;
  logic [N-1:0]        mem_wdata;
  logic                StallM;
  logic                DoneM;
  logic [R-1:0][N-1:0] ReadDataM;

  vector_mem_sequencer #(.I(I), .N(N), .R(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .StallM     (StallM),
    .DoneM      (DoneM),
    .ReadDataM  (ReadDataM)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: byte memory and the vector the load buffer should show.
  logic [N-1:0]        mem [logic [I-1:0]];
  logic [R*N-1:0]      exp_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] mem_read(input logic [I-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[N-1:0] ^ 8'hC3;
  endfunction

  function automatic logic [R*N-1:0] rand_vec();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[R*N-1:0];
  endfunction

  // One instruction, entered at a falling edge while the DUT is idle.
  // mode 0: ready always; 1: random waits; 2: three waits on stall_lane.
  // abort_lane >= 0 pulls reset at the start of that lane's first cycle.
  task automatic run_op(input bit we, input logic [I-1:0] addr, input logic [R*N-1:0] wd,
                        input int mode, input int stall_lane, input bit hold_req,
                        input int abort_lane);
    int            stalls;
    int            total_waits;
    int            waits;
    logic [I-1:0]  a;
    logic [N-1:0]  d;
    stalls      = 0;
    total_waits = 0;
    MemReqM    = 1'b1;
    MemWriteM  = we;
    AddrM      = addr;
    WriteDataM = wd;
    mem_ready  = 1'($urandom);
    mem_rdata  = 8'($urandom);
    #1;
    chk("req_cycle_stall", 64'(StallM), 64'd1);
    chk("req_cycle_memreq", 64'(mem_req), 64'd0);
    chk("req_cycle_done", 64'(DoneM), 64'd0);
    if (StallM) stalls++;
    for (int k = 0; k < R; k++) begin
      a = addr + I'(k);
      if (mode == 2 && k == stall_lane) waits = 3;
      else if (mode == 1)               waits = $urandom_range(0, 2);
      else                              waits = 0;
      total_waits += waits;
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        if (k == abort_lane && w == 0) begin
          reset = 1'b0;
          #1;
          chk("rst_memreq", 64'(mem_req), 64'd0);
          chk("rst_stall", 64'(StallM), 64'd0);
          chk("rst_done", 64'(DoneM), 64'd0);
          chk("rst_rdata", 64'(ReadDataM), 64'd0);
          exp_rd = '0;
          @(negedge clk);
          reset   = 1'b1;
          MemReqM = 1'b0;
          #1;
          chk("post_rst_memreq", 64'(mem_req), 64'd0);
          return;
        end
        AddrM      = $urandom;
        WriteDataM = rand_vec();
        MemWriteM  = 1'($urandom);
        MemReqM    = 1'($urandom);
        mem_ready  = (w == waits);
        d          = mem_read(a);
        mem_rdata  = mem_ready ? d : 8'($urandom);
        #1;
        chk("beat_req", 64'(mem_req), 64'd1);
        chk("beat_we", 64'(mem_we), 64'(we));
        chk("beat_addr", 64'(mem_addr), 64'(a));
        if (we) chk("beat_wdata", 64'(mem_wdata), 64'(wd[k*N +: N]));
        chk("beat_stall", 64'(StallM), 64'd1);
        chk("beat_done", 64'(DoneM), 64'd0);
        if (StallM) stalls++;
        if (mem_ready) begin
          if (we) mem[a] = wd[k*N +: N];
          else    exp_rd[k*N +: N] = d;
        end
      end
    end
    @(negedge clk);
    MemReqM   = hold_req;
    mem_ready = 1'($urandom);
    #1;
    chk("done_pulse", 64'(DoneM), 64'd1);
    chk("done_stall", 64'(StallM), 64'd0);
    chk("done_memreq", 64'(mem_req), 64'd0);
    chk("done_rdata", 64'(ReadDataM), 64'(exp_rd));
    chk("stall_cycles", 64'(stalls), 64'(R + 1 + total_waits));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    MemReqM   = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    chk("idle_stall", 64'(StallM), 64'd0);
    chk("idle_memreq", 64'(mem_req), 64'd0);
    chk("idle_rdata", 64'(ReadDataM), 64'(exp_rd));
  endtask

  initial begin
    logic [R*N-1:0] wd;
    reset      = 1'b0;
    MemReqM    = 1'b0;
    MemWriteM  = 1'b0;
    AddrM      = '0;
    WriteDataM = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_memreq", 64'(mem_req), 64'd0);
    chk("reset_we", 64'(mem_we), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_wdata", 64'(mem_wdata), 64'd0);
    chk("reset_stall", 64'(StallM), 64'd0);
    chk("reset_done", 64'(DoneM), 64'd0);
    chk("reset_rdata", 64'(ReadDataM), 64'd0);
    reset = 1'b1;

    // Load from 0x100 with a known ramp.
    for (int k = 0; k < R; k++) mem[32'h100 + k] = 8'(8'h10 + k);
    @(negedge clk);
    run_op(1'b0, 32'h100, '0, 0, 0, 1'b0, -1);
    chk("t1_vector", 64'(ReadDataM), 64'h0000_1514_1312_1110);

    // Store 0xA0..0xA5 to 0x20; ReadDataM must keep the previous load.
    @(negedge clk);
    run_op(1'b1, 32'h20, 48'hA5A4A3A2A1A0, 0, 0, 1'b0, -1);
    chk("t2_rdata_kept", 64'(ReadDataM), 64'h0000_1514_1312_1110);
    chk("t2_mem_lane5", 64'(mem_read(32'h25)), 64'hA5);

    // Load reading back the store, with three wait cycles on lane 2.
    @(negedge clk);
    run_op(1'b0, 32'h20, '0, 2, 2, 1'b0, -1);
    chk("t3_vector", 64'(ReadDataM), 64'h0000_A5A4_A3A2_A1A0);

    // Address wrap at the top of the 32-bit space.
    @(negedge clk);
    run_op(1'b0, 32'hFFFF_FFFE, '0, 0, 0, 1'b0, -1);

    // Reset during lane 3 of a load, then a fresh load restarts at lane 0.
    @(negedge clk);
    run_op(1'b0, 32'h300, '0, 0, 0, 1'b0, 3);
    @(negedge clk);
    run_op(1'b0, 32'h400, '0, 1, 0, 1'b0, -1);

    // Back-to-back with MemReqM held through DONE.
    @(negedge clk);
    run_op(1'b1, 32'h500, 48'h0102_0304_0506, 0, 0, 1'b1, -1);
    @(negedge clk);
    run_op(1'b0, 32'h500, '0, 0, 0, 1'b1, -1);
    chk("t6_vector", 64'(ReadDataM), 64'h0000_0102_0304_0506);
    @(negedge clk);
    run_op(1'b0, 32'h100, '0, 0, 0, 1'b0, -1);

    // Randomised traffic over a small address window so stores get read back.
    for (int t = 0; t < 40; t++) begin
      bit hold;
      hold = 1'($urandom);
      wd   = rand_vec();
      if ($urandom_range(0, 2) == 0) idle_cycle();
      @(negedge clk);
      run_op(1'($urandom), 32'h800 + I'($urandom_range(0, 15)), wd, 1, 0, hold,
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, R - 1)) : -1);
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
